exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Parametrised phase sequencer and run controller for the multi-cycle CPU.
- Generates the one-hot instruction phase and the per-instruction strobes.
- Owns run/stop/single-step/halt control, address breakpoints and a retired-instruction counter.
- Sits between the board buttons (exec, step) and the datapath. It replaces the hard-wired 5-phase counter and ad-hoc running/stop flags with one FSM.

Parameters:
- PHASES, 5: phases per instruction; one-hot width; legal range 2..16.
- ADDR_W, 16: PC width compared by the breakpoints.
- BP_COUNT, 2: number of independent breakpoint comparators; legal range 1..8.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; all state to reset values.
- clear  in  1  synchronous soft clear; same values as reset.
- exec  in  1  run/stop button, level; rising edge detected internally.
- step  in  1  single-step button, level; rising edge detected internally.
- halt  in  1  from decode; HALT instruction present; sampled in the last phase.
- pc  in  ADDR_W  current PC from the program counter.
- bp_addr  in  BP_COUNT*ADDR_W  breakpoint addresses; slot k at bits [k*ADDR_W +: ADDR_W].
- bp_en  in  BP_COUNT  per-slot breakpoint enable.
- phase  out  PHASES  one-hot phase; bit 0 = fetch.
- active  out  1  high when phase advances this cycle; datapath qualifies all writes with it.
- instr_start  out  1  one-cycle pulse in the cycle phase[0] is active and active=1.
- instr_done  out  1  one-cycle pulse in the cycle phase[PHASES-1] is active and active=1.
- state  out  3  FSM state encoding.
- stop_cause  out  3  reason for the last stop.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset and clear values:
  - state=IDLE, phase=1, active=0, stop_cause=0.
  - instr_count=0, edge-detect registers=0, bp_skip=0.
- FSM state encoding: IDLE=0, RUN=1, STOPPING=2, STEP=3, HALTED=4.
- Edge detection: exec_rise and step_rise are registered-edge pulses, one cycle after the button's rising edge. A held button gives exactly one pulse.
- active equals 1 in RUN, STOPPING and STEP, else 0.
- Phase advance: when active=1, phase rotates left by one each cycle, and phase[PHASES-1] wraps to phase[0]. When active=0, phase holds.
- IDLE:
  - exec_rise: go to RUN, set bp_skip=1, stop_cause=0.
  - Otherwise step_rise: go to STEP, stop_cause=0.
  - exec_rise wins over step_rise when both occur in the same cycle.
- RUN:
  - exec_rise: go to STOPPING.
  - Breakpoint hit: in a cycle with phase[0] active, bp_skip=0 and any enabled slot equal to pc.
    - Go to IDLE with stop_cause=2, before the phase advances.
    - phase stays 1; that instruction has not started, so instr_start still pulses in that cycle.
  - bp_skip clears at the first phase[0]-to-phase[1] advance after entering RUN. Resuming at a breakpointed PC therefore executes it.
- STOPPING: behaves like RUN but breakpoints are ignored. It completes the current instruction and enters IDLE with stop_cause=1 when phase[PHASES-1] is active.
- STEP: executes exactly one instruction (PHASES active cycles), then enters IDLE with stop_cause=4. Breakpoints are ignored. exec_rise and step_rise are ignored while in STEP.
- Halt:
  - In RUN, STOPPING or STEP, with phase[PHASES-1] active and halt=1, go to HALTED with stop_cause=3 and phase returning to 1.
  - Halt has priority over the user stop and the step stop in that cycle.
- HALTED: exec and step are ignored. Only reset or clear leave HALTED.
- Stop ordering: every stop lands with phase=1 in the cycle after the transition. The exception is a breakpoint stop, where phase never left 1.
- instr_count increments by 1 on every instr_done, including halt and step instructions. It wraps modulo 2^CNT_W.
- clear is honoured in any state, including mid-instruction. It overrides every other input in the same cycle.
- Asynchronous reset assertion mid-instruction forces the reset values immediately. Deassertion is synchronised by the system reset logic upstream.

Test Plan:
- With PHASES=5: reset, then an exec pulse. Required: state=RUN two cycles after the button edge; phase sequence 1,2,4,8,16,1,...; instr_done every 5th cycle; instr_count=3 after 15 active cycles.
- Exec pulse while running in phase=4. Required: phases 8 and 16 complete, then state=IDLE, phase=1, stop_cause=1, with no extra instr_start.
- bp_en=01, bp_addr[0]=0x0004, pc stepping 0,1,2,... per instruction. Required: stop at pc=4 with phase=1, stop_cause=2 and instr_count=4. The next exec executes pc=4 and continues to pc=5.
- From IDLE, step held high for 20 cycles. Required: exactly one instruction (5 active cycles), then IDLE with stop_cause=4 and instr_count+1.
- halt=1 presented in phase 16 of the 3rd instruction. Required: HALTED, phase=1, stop_cause=3, instr_count=3; exec and step are then ignored, and clear returns to IDLE with count 0.
- reset pulled low in phase=4 of a RUN. Required: phase=1, state=IDLE, active=0 and instr_count=0 without waiting for a clock edge.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Bundle between the run/step controls, the datapath and the exec_sequencer.
// The master modport drives buttons, decode and PC; the slave modport is the sequencer.
interface exec_sequencer_if #(
   parameter int unsigned PHASES   = 5,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned BP_COUNT = 2,
   parameter int unsigned CNT_W    = 32
);
   logic                         clear;
   logic                         exec;
   logic                         step;
   logic                         halt;
   logic [ADDR_W-1:0]            pc;
   logic [BP_COUNT*ADDR_W-1:0]   bp_addr;
   logic [BP_COUNT-1:0]          bp_en;
   logic [PHASES-1:0]            phase;
   logic                         active;
   logic                         instr_start;
   logic                         instr_done;
   logic [2:0]                   state;
   logic [2:0]                   stop_cause;
   logic [CNT_W-1:0]             instr_count;

   modport master (
      output clear, exec, step, halt, pc, bp_addr, bp_en,
      input  phase, active, instr_start, instr_done, state, stop_cause, instr_count
   );

   modport slave (
      input  clear, exec, step, halt, pc, bp_addr, bp_en,
      output phase, active, instr_start, instr_done, state, stop_cause, instr_count
   );
endinterface

// File: rtl/exec_sequencer.sv
// One-hot phase sequencer and run/stop/step/halt controller for the multi-cycle CPU,
// with address breakpoints and a retired-instruction counter.
module exec_sequencer #(
   parameter int unsigned PHASES   = 5,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned BP_COUNT = 2,
   parameter int unsigned CNT_W    = 32
) (
   input logic              clk_i,
   input logic              rst_ni,
   exec_sequencer_if.slave  bus
);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StRun      = 3'd1;
   localparam logic [2:0] StStopping = 3'd2;
   localparam logic [2:0] StStep     = 3'd3;
   localparam logic [2:0] StHalted   = 3'd4;

   localparam logic [2:0] CauseNone = 3'd0;
   localparam logic [2:0] CauseUser = 3'd1;
   localparam logic [2:0] CauseBp   = 3'd2;
   localparam logic [2:0] CauseHalt = 3'd3;
   localparam logic [2:0] CauseStep = 3'd4;

   localparam logic [PHASES-1:0] PhaseFetch = PHASES'(1);

   logic [2:0]        state_q, state_d;
   logic [PHASES-1:0] phase_q, phase_d;
   logic [2:0]        cause_q, cause_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              bp_skip_q, bp_skip_d;
   logic              exec_q, step_q;
   logic              exec_rise_q, step_rise_q;

   logic active;
   logic first_phase, last_phase;
   logic bp_hit;

   assign active      = (state_q == StRun) || (state_q == StStopping) || (state_q == StStep);
   assign first_phase = phase_q[0];
   assign last_phase  = phase_q[PHASES-1];

   always_comb begin
      bp_hit = 1'b0;
      for (int k = 0; k < int'(BP_COUNT); k++) begin
         if (bus.bp_en[k] && (bus.bp_addr[k*ADDR_W +: ADDR_W] == bus.pc)) begin
            bp_hit = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cause_d   = cause_q;
      count_d   = count_q;
      bp_skip_d = bp_skip_q;

      if (active) begin
         phase_d = {phase_q[PHASES-2:0], phase_q[PHASES-1]};
         if (last_phase) begin
            count_d = count_q + CNT_W'(1);
         end
      end

      case (state_q)
         StIdle: begin
            if (exec_rise_q) begin
               state_d   = StRun;
               bp_skip_d = 1'b1;
               cause_d   = CauseNone;
            end else if (step_rise_q) begin
               state_d = StStep;
               cause_d = CauseNone;
            end
         end
         StRun: begin
            if (first_phase) begin
               bp_skip_d = 1'b0;
            end
            if (last_phase && bus.halt) begin
               state_d = StHalted;
               cause_d = CauseHalt;
            end else if (first_phase && !bp_skip_q && bp_hit) begin
               // Stop before the fetch commits: phase never leaves fetch.
               state_d = StIdle;
               cause_d = CauseBp;
               phase_d = phase_q;
            end else if (exec_rise_q) begin
               if (last_phase) begin
                  state_d = StIdle;
                  cause_d = CauseUser;
               end else begin
                  state_d = StStopping;
               end
            end
         end
         StStopping: begin
            if (last_phase) begin
               state_d = bus.halt ? StHalted : StIdle;
               cause_d = bus.halt ? CauseHalt : CauseUser;
            end
         end
         StStep: begin
            if (last_phase) begin
               state_d = bus.halt ? StHalted : StIdle;
               cause_d = bus.halt ? CauseHalt : CauseStep;
            end
         end
         StHalted: begin
            phase_d = PhaseFetch;
         end
         default: begin
            state_d = StIdle;
            phase_d = PhaseFetch;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         phase_q     <= PhaseFetch;
         cause_q     <= CauseNone;
         count_q     <= '0;
         bp_skip_q   <= 1'b0;
         exec_q      <= 1'b0;
         step_q      <= 1'b0;
         exec_rise_q <= 1'b0;
         step_rise_q <= 1'b0;
      end else if (bus.clear) begin
         state_q     <= StIdle;
         phase_q     <= PhaseFetch;
         cause_q     <= CauseNone;
         count_q     <= '0;
         bp_skip_q   <= 1'b0;
         exec_q      <= 1'b0;
         step_q      <= 1'b0;
         exec_rise_q <= 1'b0;
         step_rise_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cause_q     <= cause_d;
         count_q     <= count_d;
         bp_skip_q   <= bp_skip_d;
         exec_q      <= bus.exec;
         step_q      <= bus.step;
         exec_rise_q <= bus.exec & ~exec_q;
         step_rise_q <= bus.step & ~step_q;
      end
   end

   assign bus.phase       = phase_q;
   assign bus.active      = active;
   assign bus.instr_start = active & first_phase;
   assign bus.instr_done  = active & last_phase;
   assign bus.state       = state_q;
   assign bus.stop_cause  = cause_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed scenarios push expected events,
// a negedge monitor pops and compares state changes, instr_start and instr_done.
module tb_exec_sequencer;

   localparam logic [1:0] EvState = 2'd0;
   localparam logic [1:0] EvStart = 2'd1;
   localparam logic [1:0] EvDone  = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
   } ev_t;

   logic clk;
   logic rst_n;
   logic [15:0] pc_tb;
   logic [2:0]  prev_state;
   bit          mon_en;
   int          n_vec;
   int          n_err;
   ev_t         exp_q[$];

   exec_sequencer_if #(.PHASES(5), .ADDR_W(16), .BP_COUNT(2), .CNT_W(32)) bus ();

   exec_sequencer #(.PHASES(5), .ADDR_W(16), .BP_COUNT(2), .CNT_W(32)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the datapath PC: advances once per retired instruction.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_tb <= '0;
      else if (bus.clear) pc_tb <= '0;
      else if (bus.instr_done) pc_tb <= pc_tb + 16'd1;
   end
   assign bus.pc = pc_tb;

   function automatic void push(input logic [1:0] kind, input int a, input int b,
                                input int c, input int d);
      ev_t e;
      e.kind = kind;
      e.a = a;
      e.b = b;
      e.c = c;
      e.d = d;
      exp_q.push_back(e);
   endfunction

   function automatic void observe(input ev_t got);
      ev_t want;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0h c=%0h d=%0h, required none",
                  got.kind, got.a, got.b, got.c, got.d);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            n_err++;
            $display("FAIL event: got kind=%0d a=%0h b=%0h c=%0h d=%0h, required kind=%0d a=%0h b=%0h c=%0h d=%0h",
                     got.kind, got.a, got.b, got.c, got.d,
                     want.kind, want.a, want.b, want.c, want.d);
         end
      end
   endfunction

   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         if (bus.state != prev_state) begin
            e = '{EvState, 32'(bus.state), 32'(bus.phase), 32'(bus.stop_cause), bus.instr_count};
            observe(e);
         end
         prev_state = bus.state;
         if (bus.instr_start) begin
            e = '{EvStart, 32'(pc_tb), 32'd0, 32'd0, 32'd0};
            observe(e);
         end
         if (bus.instr_done) begin
            e = '{EvDone, 32'(pc_tb), bus.instr_count, 32'd0, 32'd0};
            observe(e);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic press(input bit is_step, input int cycles);
      if (is_step) bus.step = 1'b1;
      else bus.exec = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      bus.step = 1'b0;
      bus.exec = 1'b0;
   endtask

   task automatic wait_phase(input logic [4:0] ph, input int pc, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (bus.active && bus.phase == ph && int'(pc_tb) == pc) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL wait_phase: phase %0h at pc %0d not seen, required within %0d cycles",
               ph, pc, budget);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s: %0d events outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
   endtask

   initial begin
      logic [4:0] seq [5];
      seq[0] = 5'd2; seq[1] = 5'd4; seq[2] = 5'd8; seq[3] = 5'd16; seq[4] = 5'd1;
      n_vec = 0;
      n_err = 0;
      mon_en = 1'b0;
      prev_state = 3'd0;
      rst_n = 1'b0;
      bus.clear = 1'b0;
      bus.exec = 1'b0;
      bus.step = 1'b0;
      bus.halt = 1'b0;
      bus.bp_en = 2'b00;
      bus.bp_addr = {16'h0002, 16'h0004};
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_state", 32'(bus.state), 32'd0);
      check("reset_phase", 32'(bus.phase), 32'd1);
      check("reset_active", 32'(bus.active), 32'd0);
      check("reset_cause_count", {29'd0, bus.stop_cause} | bus.instr_count, 32'd0);
      mon_en = 1'b1;

      // Free run for three instructions, then a user stop raised in phase 4.
      push(EvState, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         push(EvStart, i, 0, 0, 0);
         push(EvDone, i, i, 0, 0);
      end
      push(EvStart, 3, 0, 0, 0);
      push(EvState, 2, 8, 0, 3);
      push(EvDone, 3, 3, 0, 0);
      push(EvState, 0, 1, 1, 4);
      press(1'b0, 2);
      check("run_two_cycles_after_edge", 32'(bus.state), 32'd1);
      check("run_first_phase", 32'(bus.phase), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("phase_sequence", 32'(bus.phase), 32'(seq[i]));
      end
      wait_phase(5'd2, 3, 40);
      check("count_after_15_active", bus.instr_count, 32'd3);
      press(1'b0, 3);
      drain("user_stop", 40);
      check("user_stop_phase", 32'(bus.phase), 32'd1);

      // Breakpoint at pc 4 (slot 1 disabled at pc 2), then resume through it.
      pulse_clear();
      bus.bp_en = 2'b01;
      push(EvState, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         push(EvStart, i, 0, 0, 0);
         push(EvDone, i, i, 0, 0);
      end
      push(EvStart, 4, 0, 0, 0);
      push(EvState, 0, 1, 2, 4);
      press(1'b0, 2);
      drain("bp_stop", 60);
      check("bp_stop_pc", 32'(pc_tb), 32'd4);
      push(EvState, 1, 1, 0, 4);
      push(EvStart, 4, 0, 0, 0);
      push(EvDone, 4, 4, 0, 0);
      push(EvStart, 5, 0, 0, 0);
      push(EvState, 2, 8, 0, 5);
      push(EvDone, 5, 5, 0, 0);
      push(EvState, 0, 1, 1, 6);
      press(1'b0, 2);
      wait_phase(5'd2, 5, 40);
      press(1'b0, 3);
      drain("bp_resume", 40);

      // Step button held for 20 cycles retires exactly one instruction.
      push(EvState, 3, 1, 0, 6);
      push(EvStart, 6, 0, 0, 0);
      push(EvDone, 6, 6, 0, 0);
      push(EvState, 0, 1, 4, 7);
      press(1'b1, 20);
      drain("single_step", 20);
      check("step_count", bus.instr_count, 32'd7);

      // HALT seen in the last phase of the third instruction.
      pulse_clear();
      push(EvState, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         push(EvStart, i, 0, 0, 0);
         push(EvDone, i, i, 0, 0);
      end
      push(EvState, 4, 1, 3, 3);
      press(1'b0, 2);
      wait_phase(5'd16, 2, 40);
      bus.halt = 1'b1;
      @(posedge clk);
      #1;
      bus.halt = 1'b0;
      drain("halt", 20);
      press(1'b0, 3);
      repeat (3) @(posedge clk);
      press(1'b1, 3);
      repeat (6) @(posedge clk);
      #1;
      check("halted_ignores_buttons", 32'(bus.state), 32'd4);
      push(EvState, 0, 1, 0, 0);
      pulse_clear();
      drain("clear_from_halt", 10);
      check("clear_count", bus.instr_count, 32'd0);

      // Asynchronous reset in phase 4 of the second instruction.
      push(EvState, 1, 1, 0, 0);
      push(EvStart, 0, 0, 0, 0);
      push(EvDone, 0, 0, 0, 0);
      push(EvStart, 1, 0, 0, 0);
      push(EvState, 0, 1, 0, 0);
      press(1'b0, 2);
      wait_phase(5'd4, 1, 40);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", {bus.instr_count[15:0], 5'd0, bus.state, 3'd0, bus.active, bus.phase},
            {16'd0, 5'd0, 3'd0, 3'd0, 1'b0, 5'd1});
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drain("reset_event", 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
